// File: rtl/kbd_lcd_bus_sched.sv
// Purpose: generic show-ahead FIFO that holds key events until the host path pops them.
// Latency: a push becomes visible at the head one cycle later; a pop takes effect at the next edge.
// Backpressure: full is reported upstream; a push while full is dropped; a pop while empty is ignored.
module kbd_lcd_bus_sched_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         full,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_rdy && pop_vld;

    // Storage array: written only, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: time-shares the 8 LCD-data/keyboard-row pads between the LCD writer and a column scanner.
// Latency: LCD grant one cycle after request in IDLE; one scan slot is 2*TURN+SETTLE+1 cycles.
// Backpressure: LCD holds the bus until lcd_done; a full event FIFO defers a row change to a later pass.
module kbd_lcd_bus_sched #(
    parameter int NUM_COLS    = 9,
    parameter int SCAN_PERIOD = 4800,
    parameter int SETTLE      = 48,
    parameter int TURN        = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                scan_en,
    input  logic                lcd_req,
    output logic                lcd_gnt,
    input  logic                lcd_done,
    input  logic [7:0]          lcd_data,
    output logic                bus_oe,
    output logic [7:0]          bus_dout,
    input  logic [7:0]          bus_din,
    output logic [NUM_COLS-1:0] col_drive,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [3:0]          key_col,
    output logic [7:0]          key_rows
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LCD_OWN    = 3'd1;
    localparam logic [2:0] S_KB_TURN    = 3'd2;
    localparam logic [2:0] S_KB_SETTLE  = 3'd3;
    localparam logic [2:0] S_KB_SAMPLE  = 3'd4;
    localparam logic [2:0] S_KB_RELEASE = 3'd5;

    localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int CW = $clog2(SETTLE + TURN + 1) + 1;

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic          tmr_wrap;
    logic          scan_pending;
    logic          last_kb;
    logic [3:0]    col_idx;
    logic [7:0]    snap [NUM_COLS];
    logic [7:0]    rows_now;
    logic          ev_push;
    logic          ev_full;
    logic [11:0]   ev_head;

    assign tmr_wrap = (tmr == TW'(SCAN_PERIOD - 1));
    assign rows_now = ~bus_din;
    assign ev_push  = (state == S_KB_SAMPLE) && (rows_now != snap[col_idx]) && !ev_full;
    assign bus_dout = (state == S_LCD_OWN) ? lcd_data : 8'h00;
    assign key_col  = ev_head[11:8];
    assign key_rows = ev_head[7:0];

    // Next-state: keyboard normally wins a tie, but yields to a waiting LCD right after its own slot.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (scan_pending && scan_en && !(lcd_req && last_kb)) nxt = S_KB_TURN;
                else if (lcd_req)                                      nxt = S_LCD_OWN;
            end
            S_LCD_OWN:    if (lcd_done)                 nxt = S_IDLE;
            S_KB_TURN:    if (cnt == CW'(TURN - 1))     nxt = S_KB_SETTLE;
            S_KB_SETTLE:  if (cnt == CW'(SETTLE - 1))   nxt = S_KB_SAMPLE;
            S_KB_SAMPLE:                                nxt = S_KB_RELEASE;
            S_KB_RELEASE: if (cnt == CW'(TURN - 1))     nxt = S_IDLE;
            default:                                    nxt = S_IDLE;
        endcase
    end

    // State, phase counter and registered pad controls, all derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lcd_gnt   <= 1'b0;
            bus_oe    <= 1'b0;
            col_drive <= '1;
            last_kb   <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state || state == S_IDLE || state == S_LCD_OWN) cnt <= '0;
            else                                                        cnt <= cnt + CW'(1);
            lcd_gnt <= (nxt == S_LCD_OWN);
            bus_oe  <= (nxt == S_LCD_OWN);
            if (nxt == S_KB_SETTLE || nxt == S_KB_SAMPLE) col_drive <= ~(NUM_COLS'(1) << col_idx);
            else                                          col_drive <= '1;
            if (state == S_KB_RELEASE && nxt == S_IDLE)   last_kb <= 1'b1;
            else if (state == S_IDLE && nxt == S_LCD_OWN) last_kb <= 1'b0;
        end
    end

    // Free-running slot timer; a wrap leaves a sticky request that only a slot start consumes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr          <= '0;
            scan_pending <= 1'b0;
        end else begin
            tmr <= tmr_wrap ? '0 : tmr + TW'(1);
            if (tmr_wrap)                                scan_pending <= 1'b1;
            else if (state == S_IDLE && nxt == S_KB_TURN) scan_pending <= 1'b0;
        end
    end

    // Column walk and per-column row snapshot; a dropped event keeps the old snapshot so it recurs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_idx <= '0;
            for (int i = 0; i < NUM_COLS; i++) snap[i] <= '0;
        end else if (state == S_KB_SAMPLE) begin
            if (ev_push) snap[col_idx] <= rows_now;
            col_idx <= (col_idx == 4'(NUM_COLS - 1)) ? 4'd0 : col_idx + 4'd1;
        end
    end

    kbd_lcd_bus_sched_fifo #(
        .W     (12),
        .DEPTH (FIFO_DEPTH)
    ) u_ev_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (ev_push),
        .push_dat ({col_idx, rows_now}),
        .full     (ev_full),
        .pop_vld  (key_valid),
        .pop_rdy  (key_ready),
        .pop_dat  (ev_head)
    );
endmodule

// File: tb/tb_kbd_lcd_bus_sched.sv
// Directed bench for kbd_lcd_bus_sched with a shortened scan period.
module tb_kbd_lcd_bus_sched;
    localparam int SP     = 200;
    localparam int NC     = 9;
    localparam int TURN   = 2;
    localparam int SETTLE = 48;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          scan_en = 1'b0;
    logic          lcd_req = 1'b0;
    logic          lcd_done = 1'b0;
    logic          key_ready = 1'b0;
    logic [7:0]    lcd_data = 8'h00;
    logic [7:0]    bus_din;
    logic          lcd_gnt;
    logic          bus_oe;
    logic [7:0]    bus_dout;
    logic [NC-1:0] col_drive;
    logic          key_valid;
    logic [3:0]    key_col;
    logic [7:0]    key_rows;
    logic [7:0]    keys [NC];

    int n_checks = 0;
    int n_fail   = 0;

    kbd_lcd_bus_sched #(
        .NUM_COLS(NC), .SCAN_PERIOD(SP), .SETTLE(SETTLE), .TURN(TURN), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .lcd_req(lcd_req),
        .lcd_gnt(lcd_gnt), .lcd_done(lcd_done), .lcd_data(lcd_data), .bus_oe(bus_oe),
        .bus_dout(bus_dout), .bus_din(bus_din), .col_drive(col_drive),
        .key_valid(key_valid), .key_ready(key_ready), .key_col(key_col), .key_rows(key_rows)
    );

    always #5 clk = ~clk;

    // Key matrix: pulled-up rows, a pressed key pulls its row low while its column is driven.
    always_comb begin
        bus_din = 8'hFF;
        for (int c = 0; c < NC; c++) begin
            if (!col_drive[c]) bus_din = bus_din & ~keys[c];
        end
    end

    // Reference copy of the slot timer phase.
    int tmr = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmr <= 0;
        else          tmr <= (tmr == SP - 1) ? 0 : tmr + 1;
    end

    // Bus observer: slot starts, drive length, and the safety rules.
    int            slot_cnt = 0;
    int            low_run = 0;
    int            last_low_len = 0;
    int            since = 100;
    int            viol_both = 0;
    int            viol_oe = 0;
    int            viol_hot = 0;
    logic [NC-1:0] prev_cd = '1;
    logic [NC-1:0] slot_pat = '1;
    always @(posedge clk) begin
        #1;
        if (col_drive != '1 && prev_cd == '1) begin
            slot_cnt = slot_cnt + 1;
            slot_pat = col_drive;
        end
        if (col_drive != '1) begin
            low_run = low_run + 1;
            since = 0;
        end else begin
            if (low_run != 0) last_low_len = low_run;
            low_run = 0;
            if (since < 100) since = since + 1;
        end
        if (lcd_gnt && col_drive != '1) viol_both = viol_both + 1;
        if (bus_oe && since <= TURN) viol_oe = viol_oe + 1;
        if ($countones(~col_drive) > 1) viol_hot = viol_hot + 1;
        prev_cd = col_drive;
    end

    task automatic wait_tmr(input int v);
        for (int i = 0; i < SP + 2; i++) begin
            if (tmr == v) return;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (lcd_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", lcd_gnt); end
        n_checks++; if (bus_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus_oe); end
        n_checks++; if (bus_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", bus_dout); end
        n_checks++; if (col_drive !== 9'h1FF) begin n_fail++; $display("FAIL reset_cols: got %h want 1ff", col_drive); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        reset_n = 1'b1;
    endtask

    task automatic test_lcd_grant();
        int bad;
        @(negedge clk);
        lcd_data = 8'hA5;
        lcd_req  = 1'b1;
        @(negedge clk);
        n_checks++; if (lcd_gnt !== 1'b1) begin n_fail++; $display("FAIL lcd_gnt_lat: got %b want 1", lcd_gnt); end
        n_checks++; if (bus_oe !== 1'b1) begin n_fail++; $display("FAIL lcd_oe: got %b want 1", bus_oe); end
        n_checks++; if (bus_dout !== 8'hA5) begin n_fail++; $display("FAIL lcd_dout: got %h want a5", bus_dout); end
        lcd_data = 8'h3C;
        #1;
        n_checks++; if (bus_dout !== 8'h3C) begin n_fail++; $display("FAIL lcd_dout_comb: got %h want 3c", bus_dout); end
        lcd_req = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (lcd_gnt !== 1'b1 || col_drive !== 9'h1FF) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL lcd_hold: got %0d bad cycles want 0", bad); end
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        n_checks++; if (lcd_gnt !== 1'b0 || bus_oe !== 1'b0) begin n_fail++; $display("FAIL lcd_release: got gnt=%b oe=%b want 0 0", lcd_gnt, bus_oe); end
        n_checks++; if (bus_dout !== 8'h00) begin n_fail++; $display("FAIL lcd_dout_idle: got %h want 00", bus_dout); end
    endtask

    task automatic test_scan_key();
        int s0;
        s0 = slot_cnt;
        keys[3] = 8'h20;
        scan_en = 1'b1;
        for (int i = 0; i < 6 * SP && !key_valid; i++) @(negedge clk);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL press_event: got kv=%b want 1", key_valid); end
        n_checks++; if (slot_cnt - s0 !== 4) begin n_fail++; $display("FAIL press_slot: got slot %0d want 4", slot_cnt - s0); end
        n_checks++; if ({key_col, key_rows} !== {4'd3, 8'h20}) begin n_fail++; $display("FAIL press_dat: got %0d/%h want 3/20", key_col, key_rows); end
        n_checks++; if (last_low_len !== SETTLE + 1) begin n_fail++; $display("FAIL drive_len: got %0d want %0d", last_low_len, SETTLE + 1); end
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty: got kv=%b want 0", key_valid); end
        keys[3] = 8'h00;
        for (int i = 0; i < 10 * SP && !key_valid; i++) @(negedge clk);
        n_checks++; if (key_valid !== 1'b1 || {key_col, key_rows} !== {4'd3, 8'h00}) begin
            n_fail++; $display("FAIL release_event: got kv=%b %0d/%h want 1 3/00", key_valid, key_col, key_rows);
        end
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        repeat (10 * SP) @(negedge clk);
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL no_repeat: got kv=%b want 0", key_valid); end
    endtask

    task automatic test_arbitration();
        int s0;
        scan_en = 1'b0;
        repeat (60) @(negedge clk);
        lcd_req = 1'b1;
        for (int i = 0; i < 5 && !lcd_gnt; i++) @(negedge clk);
        n_checks++; if (lcd_gnt !== 1'b1) begin n_fail++; $display("FAIL arb_pre_gnt: got %b want 1", lcd_gnt); end
        scan_en = 1'b1;
        wait_tmr(SP - 1);
        @(negedge clk);
        wait_tmr(20);
        wait_tmr(SP - 20);
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        n_checks++; if (lcd_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_drop: got %b want 0", lcd_gnt); end
        s0 = slot_cnt;
        for (int i = 0; i < 120 && !lcd_gnt; i++) @(negedge clk);
        n_checks++; if (lcd_gnt !== 1'b1 || slot_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL arb_kb_first: got gnt=%b slots=%0d want 1 1", lcd_gnt, slot_cnt - s0);
        end
        lcd_done = 1'b1;
        lcd_req  = 1'b0;
        @(negedge clk);
        lcd_done = 1'b0;
        s0 = slot_cnt;
        repeat (60) @(negedge clk);
        n_checks++; if (slot_cnt - s0 !== 1) begin n_fail++; $display("FAIL arb_pending_kept: got %0d slots want 1", slot_cnt - s0); end
    endtask

    task automatic test_lcd_long();
        int s0;
        wait_tmr(150);
        lcd_req = 1'b1;
        @(negedge clk);
        n_checks++; if (lcd_gnt !== 1'b1) begin n_fail++; $display("FAIL long_gnt: got %b want 1", lcd_gnt); end
        s0 = slot_cnt;
        wait_tmr(0);
        @(negedge clk);
        wait_tmr(0);
        @(negedge clk);
        wait_tmr(10);
        n_checks++; if (lcd_gnt !== 1'b1 || slot_cnt !== s0) begin
            n_fail++; $display("FAIL long_hold: got gnt=%b slots=%0d want 1 0", lcd_gnt, slot_cnt - s0);
        end
        lcd_done = 1'b1;
        lcd_req  = 1'b0;
        @(negedge clk);
        lcd_done = 1'b0;
        wait_tmr(SP - 10);
        n_checks++; if (slot_cnt - s0 !== 1) begin n_fail++; $display("FAIL long_one_slot: got %0d slots want 1", slot_cnt - s0); end
    endtask

    task automatic test_fifo_full();
        int n;
        int bad;
        logic [NC-1:0] mask;
        keys[0] = 8'h81; keys[1] = 8'h42; keys[2] = 8'h24;
        keys[4] = 8'h18; keys[5] = 8'h0F; keys[6] = 8'hF0;
        mask = '0;
        bad  = 0;
        repeat (10 * SP) @(negedge clk);
        n = 0;
        for (int i = 0; i < 8 && key_valid; i++) begin
            if (key_rows !== keys[key_col]) bad++;
            mask[key_col] = 1'b1;
            n++;
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
        end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL full_first: got %0d events want 4", n); end
        repeat (10 * SP) @(negedge clk);
        n = 0;
        for (int i = 0; i < 8 && key_valid; i++) begin
            if (key_rows !== keys[key_col]) bad++;
            mask[key_col] = 1'b1;
            n++;
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
        end
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL full_rest: got %0d events want 2", n); end
        n_checks++; if (mask !== 9'h077 || bad !== 0) begin
            n_fail++; $display("FAIL full_content: got mask=%h bad=%0d want 077 0", mask, bad);
        end
    endtask

    task automatic test_reset_mid_settle();
        int s0;
        for (int c = 0; c < NC; c++) keys[c] = 8'h00;
        for (int i = 0; i < 3 * SP && !key_valid; i++) @(negedge clk);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_kv: got %b want 1", key_valid); end
        for (int i = 0; i < 2 * SP && col_drive == 9'h1FF; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++; if (col_drive === 9'h1FF) begin n_fail++; $display("FAIL rst_pre_drive: got %h want a driven column", col_drive); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (col_drive !== 9'h1FF || bus_oe !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got cols=%h oe=%b kv=%b want 1ff 0 0", col_drive, bus_oe, key_valid);
        end
        keys[0] = 8'h01;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        s0 = slot_cnt;
        for (int i = 0; i < 3 * SP && !key_valid; i++) @(negedge clk);
        n_checks++; if (key_valid !== 1'b1 || {key_col, key_rows} !== {4'd0, 8'h01}) begin
            n_fail++; $display("FAIL rst_restart: got kv=%b %0d/%h want 1 0/01", key_valid, key_col, key_rows);
        end
        n_checks++; if (slot_pat !== 9'h1FE || slot_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL rst_col0: got pat=%h slots=%0d want 1fe 1", slot_pat, slot_cnt - s0);
        end
    endtask

    task automatic test_invariants();
        n_checks++; if (viol_both !== 0) begin n_fail++; $display("FAIL gnt_vs_cols: got %0d cycles want 0", viol_both); end
        n_checks++; if (viol_oe !== 0) begin n_fail++; $display("FAIL oe_turnaround: got %0d cycles want 0", viol_oe); end
        n_checks++; if (viol_hot !== 0) begin n_fail++; $display("FAIL cols_onehot: got %0d cycles want 0", viol_hot); end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) keys[c] = 8'h00;
        test_reset();
        test_lcd_grant();
        test_scan_key();
        test_arbitration();
        test_lcd_long();
        test_fifo_full();
        test_reset_mid_settle();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
